// File: rtl/filtro_temp_pkg.sv
// filtro_temp_pkg: shared types and constants for the temperature conditioning and monitoring blocks.
package filtro_temp_pkg;
    localparam int W_TEMP = 11;
    localparam logic signed [W_TEMP-1:0] COD_INVALIDO_DEF = 11'sh400;
    typedef enum logic [1:0] {
        VACIO  = 2'b00,
        ACTIVO = 2'b01,
        FALLA  = 2'b10
    } estado_filtro_t;
endpackage

// File: rtl/watchdog_muestra.sv
// watchdog_muestra: saturating cycle counter with synchronous clear.
// expirado looks at the next count, so a clear in the expiry cycle suppresses it.
module watchdog_muestra #(
    parameter int MAX = 1000
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    output logic expirado
);
    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] LIM = CW'(MAX);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : (cnt_q == LIM ? cnt_q : cnt_q + CW'(1));
    end
    assign expirado = (cnt_d == LIM);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/filtro_temp.sv
// filtro_temp: rejects the invalid sensor code, averages 2^LOG2_N samples and flags sensor failure
// on sample timeout or repeated invalid codes.
module filtro_temp
    import filtro_temp_pkg::*;
#(
    parameter int LOG2_N = 2,
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int ERR_MAX = 3,
    parameter logic signed [W_TEMP-1:0] COD_INVALIDO = COD_INVALIDO_DEF
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     muestra_valida,
    input  logic signed [W_TEMP-1:0] muestra_temp,
    output logic signed [W_TEMP-1:0] temp_filtrada,
    output logic                     dato_listo,
    output logic                     temp_valida,
    output logic                     falla_sensor,
    output logic [1:0]               estado_filtro
);
    localparam int N  = 1 << LOG2_N;
    localparam int WS = W_TEMP + LOG2_N;
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam logic [EW-1:0] ERR_LIM = EW'(ERR_MAX);
    logic signed [W_TEMP-1:0] ventana_q [N];
    logic signed [W_TEMP-1:0] ventana_d [N];
    logic signed [WS-1:0]     sum_q, sum_d, sum_next, m_ext, b_ext;
    logic [LOG2_N-1:0]        ptr_q, ptr_d;
    logic [EW-1:0]            err_q, err_d;
    estado_filtro_t           estado_q, estado_d;
    logic signed [W_TEMP-1:0] temp_q, temp_d;
    logic                     listo_q, listo_d;
    logic                     aceptada, rechazada, expirado;
    assign aceptada  = muestra_valida && (muestra_temp != COD_INVALIDO);
    assign rechazada = muestra_valida && (muestra_temp == COD_INVALIDO);
    assign m_ext     = {{LOG2_N{muestra_temp[W_TEMP-1]}}, muestra_temp};
    assign b_ext     = {{LOG2_N{ventana_q[ptr_q][W_TEMP-1]}}, ventana_q[ptr_q]};
    assign sum_next  = sum_q + m_ext - b_ext;
    watchdog_muestra #(.MAX(TIMEOUT_CICLOS)) u_wd (
        .clk(clk),
        .arst_n(arst_n),
        .clr(aceptada),
        .expirado(expirado)
    );
    always_comb begin
        ventana_d = ventana_q;
        sum_d     = sum_q;
        ptr_d     = ptr_q;
        estado_d  = estado_q;
        temp_d    = temp_q;
        listo_d   = 1'b0;
        err_d     = aceptada ? '0 : ((rechazada && err_q != ERR_LIM) ? err_q + EW'(1) : err_q);
        if (aceptada) begin
            if (estado_q == ACTIVO) begin
                ventana_d[ptr_q] = muestra_temp;
                sum_d            = sum_next;
                ptr_d            = ptr_q + LOG2_N'(1);
            end else begin
                // Preload the whole window so the first output equals the sample.
                for (int i = 0; i < N; i++) ventana_d[i] = muestra_temp;
                sum_d    = m_ext <<< LOG2_N;
                ptr_d    = '0;
                estado_d = ACTIVO;
            end
            temp_d  = W_TEMP'(sum_d >>> LOG2_N);
            listo_d = 1'b1;
        end else if (estado_q == ACTIVO && (expirado || err_d == ERR_LIM)) begin
            estado_d = FALLA;
        end
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N; i++) ventana_q[i] <= '0;
            sum_q    <= '0;
            ptr_q    <= '0;
            err_q    <= '0;
            estado_q <= VACIO;
            temp_q   <= '0;
            listo_q  <= 1'b0;
        end else begin
            ventana_q <= ventana_d;
            sum_q     <= sum_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            estado_q  <= estado_d;
            temp_q    <= temp_d;
            listo_q   <= listo_d;
        end
    end
    assign temp_filtrada = temp_q;
    assign dato_listo    = listo_q;
    assign temp_valida   = (estado_q == ACTIVO);
    assign falla_sensor  = (estado_q == FALLA);
    assign estado_filtro = estado_q;
endmodule

// File: tb/tb_filtro_temp.sv
// tb_filtro_temp: directed checks of preload, averaging, floor rounding, invalid codes,
// timeout and asynchronous reset for filtro_temp (LOG2_N=2, TIMEOUT_CICLOS=20, ERR_MAX=3).
module tb_filtro_temp;
    logic clk = 1'b0;
    logic arst_n;
    logic mv;
    logic signed [10:0] mt;
    logic signed [10:0] temp_filtrada;
    logic dato_listo, temp_valida, falla_sensor;
    logic [1:0] estado_filtro;
    int checks = 0;
    int errors = 0;

    filtro_temp #(.LOG2_N(2), .TIMEOUT_CICLOS(20), .ERR_MAX(3)) dut (
        .clk(clk),
        .arst_n(arst_n),
        .muestra_valida(mv),
        .muestra_temp(mt),
        .temp_filtrada(temp_filtrada),
        .dato_listo(dato_listo),
        .temp_valida(temp_valida),
        .falla_sensor(falla_sensor),
        .estado_filtro(estado_filtro)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic signed [10:0] t);
        @(negedge clk);
        mv = v;
        mt = t;
        @(posedge clk);
        #1;
        mv = 1'b0;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        mv = 1'b0;
        mt = '0;
        #12;
        checks++;
        if ({temp_filtrada, dato_listo, temp_valida, falla_sensor, estado_filtro} !== 16'h0) begin
            errors++;
            $display("FAIL reset outs got %h exp 0", {temp_filtrada, dato_listo, temp_valida, falla_sensor, estado_filtro});
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_preload;
        cyc(1'b1, 11'sd100);
        checks++;
        if (temp_filtrada !== 11'sd100 || dato_listo !== 1'b1) begin
            errors++;
            $display("FAIL preload temp=%0d listo=%b exp 100/1", temp_filtrada, dato_listo);
        end
        checks++;
        if (estado_filtro !== 2'b01 || temp_valida !== 1'b1) begin
            errors++;
            $display("FAIL preload estado=%b valida=%b exp 01/1", estado_filtro, temp_valida);
        end
        cyc(1'b0, 11'sd0);
        checks++;
        if (temp_filtrada !== 11'sd100 || dato_listo !== 1'b0) begin
            errors++;
            $display("FAIL hold temp=%0d listo=%b exp 100/0", temp_filtrada, dato_listo);
        end
    endtask

    task automatic test_back_to_back;
        logic signed [10:0] ins [4] = '{11'sd104, 11'sd108, 11'sd112, 11'sd116};
        logic signed [10:0] exps [4] = '{11'sd101, 11'sd103, 11'sd106, 11'sd110};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, ins[i]);
            checks++;
            if (temp_filtrada !== exps[i] || dato_listo !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] temp=%0d listo=%b exp %0d/1", i, temp_filtrada, dato_listo, exps[i]);
            end
        end
    endtask

    task automatic test_invalid;
        cyc(1'b1, -11'sd1024);
        cyc(1'b1, -11'sd1024);
        checks++;
        if (estado_filtro !== 2'b01 || dato_listo !== 1'b0) begin
            errors++;
            $display("FAIL inv2 estado=%b listo=%b exp 01/0", estado_filtro, dato_listo);
        end
        cyc(1'b1, -11'sd1024);
        checks++;
        if (falla_sensor !== 1'b1 || temp_valida !== 1'b0 || estado_filtro !== 2'b10) begin
            errors++;
            $display("FAIL inv3 falla=%b valida=%b estado=%b exp 1/0/10", falla_sensor, temp_valida, estado_filtro);
        end
        checks++;
        if (temp_filtrada !== 11'sd110 || dato_listo !== 1'b0) begin
            errors++;
            $display("FAIL inv_hold temp=%0d listo=%b exp 110/0", temp_filtrada, dato_listo);
        end
        cyc(1'b1, 11'sd50);
        checks++;
        if (temp_filtrada !== 11'sd50 || estado_filtro !== 2'b01 || dato_listo !== 1'b1) begin
            errors++;
            $display("FAIL recover temp=%0d estado=%b listo=%b exp 50/01/1", temp_filtrada, estado_filtro, dato_listo);
        end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 19; i++) cyc(1'b0, 11'sd0);
        checks++;
        if (estado_filtro !== 2'b01) begin
            errors++;
            $display("FAIL to_19 estado=%b exp 01", estado_filtro);
        end
        cyc(1'b0, 11'sd0);
        checks++;
        if (estado_filtro !== 2'b10 || falla_sensor !== 1'b1 || temp_filtrada !== 11'sd50) begin
            errors++;
            $display("FAIL to_20 estado=%b falla=%b temp=%0d exp 10/1/50", estado_filtro, falla_sensor, temp_filtrada);
        end
        cyc(1'b1, 11'sd60);
        for (int i = 0; i < 19; i++) cyc(1'b0, 11'sd0);
        cyc(1'b1, 11'sd61);
        checks++;
        if (estado_filtro !== 2'b01 || temp_filtrada !== 11'sd60 || dato_listo !== 1'b1) begin
            errors++;
            $display("FAIL to_race estado=%b temp=%0d listo=%b exp 01/60/1", estado_filtro, temp_filtrada, dato_listo);
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 11'sd0);
        checks++;
        if (estado_filtro !== 2'b01) begin
            errors++;
            $display("FAIL to_after estado=%b exp 01", estado_filtro);
        end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 11'sd200);
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({temp_filtrada, dato_listo, temp_valida, falla_sensor, estado_filtro} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset outs got %h exp 0", {temp_filtrada, dato_listo, temp_valida, falla_sensor, estado_filtro});
        end
        @(negedge clk);
        arst_n = 1'b1;
        cyc(1'b1, 11'sd7);
        checks++;
        if (temp_filtrada !== 11'sd7 || estado_filtro !== 2'b01) begin
            errors++;
            $display("FAIL post_reset temp=%0d estado=%b exp 7/01", temp_filtrada, estado_filtro);
        end
        cyc(1'b1, 11'sd11);
        checks++;
        if (temp_filtrada !== 11'sd8) begin
            errors++;
            $display("FAIL post_reset2 temp=%0d exp 8", temp_filtrada);
        end
    endtask

    task automatic test_negative_floor;
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        cyc(1'b1, -11'sd3);
        checks++;
        if (temp_filtrada !== -11'sd3) begin
            errors++;
            $display("FAIL neg_pre temp=%0d exp -3", temp_filtrada);
        end
        cyc(1'b1, -11'sd4);
        checks++;
        if (temp_filtrada !== -11'sd4) begin
            errors++;
            $display("FAIL neg_floor temp=%0d exp -4", temp_filtrada);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_back_to_back();
        test_invalid();
        test_timeout();
        test_reset_mid();
        test_negative_floor();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
